// File: rtl/aes_pkg.sv
// Shared AES key-schedule constants: key_len encodings, Nk/Nr lookup, Rcon start value and xtime.
package aes_pkg;

    localparam logic [1:0] KL_128 = 2'b00;
    localparam logic [1:0] KL_192 = 2'b01;
    localparam logic [1:0] KL_256 = 2'b10;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef struct packed {
        logic [3:0] nk;
        logic [3:0] nr;
    } key_cfg_t;

    // Lengths the instance cannot hold, and the reserved code, fall back to AES-128.
    function automatic key_cfg_t key_cfg(input logic [1:0] key_len, input int unsigned max_nk);
        key_cfg_t cfg;
        cfg.nk = 4'd4;
        cfg.nr = 4'd10;
        case (key_len)
            KL_192: begin
                if (max_nk >= 6) begin
                    cfg.nk = 4'd6;
                    cfg.nr = 4'd12;
                end
            end
            KL_256: begin
                if (max_nk >= 8) begin
                    cfg.nk = 4'd8;
                    cfg.nr = 4'd14;
                end
            end
            default: ;
        endcase
        return cfg;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_sched_subword.sv
// 32-bit SubWord: four S-box lookups, one per byte.
module key_sched_subword (
    input  logic [31:0] src_word,
    output logic [31:0] sub_word
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        sbox u_sbox (
            .hi_nib  (src_word[8*b+7 -: 4]),
            .lo_nib  (src_word[8*b+3 -: 4]),
            .sub_byte(sub_word[8*b+7 -: 8])
        );
    end

endmodule

// File: rtl/sbox.sv
// AES forward S-box as a 256-entry lookup addressed by {hi_nib, lo_nib}.
module sbox (
    input  logic [3:0] hi_nib,
    input  logic [3:0] lo_nib,
    output logic [7:0] sub_byte
);

    // Row 0x0 sits in the top bits, so entry n lives at element 255-n.
    localparam logic [255:0][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub_byte = SBOX_TBL[~{hi_nib, lo_nib}];

endmodule

// File: rtl/key_sched_gen.sv
// Sequential AES-128/192/256 key expansion, one schedule word per cycle, with a round-key read port.
// Define KEY_SCHED_DEC_EN to add rk_rev, which serves round keys in decryption order.
module key_sched_gen
    import aes_pkg::*;
#(
    parameter int unsigned MAX_NK = 8,
    parameter int unsigned RD_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           key_len,
    input  logic [32*MAX_NK-1:0] key_in,
    output logic                 busy,
    output logic                 done,
    output logic                 valid,
    output logic [3:0]           nr_out,
    input  logic [3:0]           rk_idx,
`ifdef KEY_SCHED_DEC_EN
    input  logic                 rk_rev,
`endif
    output logic [127:0]         rk_out
);

    localparam int unsigned DEPTH = 4 * (MAX_NK + 7);
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StExpand} state_e;

    state_e               state_q, state_d;
    logic [32*MAX_NK-1:0] key_q;
    logic [3:0]           nk_q, nr_q;
    logic [AW-1:0]        i_q;
    logic [2:0]           m_q, m_next;
    logic [7:0]           rcon_q;
    logic                 done_q, done_d;
    logic                 valid_q, valid_d;
    logic [3:0]           nr_out_q, nr_out_d;
    logic                 accept, load_en, exp_en, last_word;
    key_cfg_t             cfg;

    logic [31:0] key_w [MAX_NK];
    logic [31:0] win_q [MAX_NK];
    logic [31:0] mem   [DEPTH];

    logic [31:0] prev_w, back_w, rot_w, sub_in, sub_out, temp_w, new_w;

    assign cfg       = key_cfg(key_len, MAX_NK);
    assign accept    = (state_q == StIdle) && start;
    assign last_word = (i_q == AW'({nr_q, 2'b11}));
    assign m_next    = ((4'(m_q) + 4'd1) == nk_q) ? 3'd0 : m_q + 3'd1;

    always_comb begin
        for (int j = 0; j < MAX_NK; j++) begin
            key_w[j] = key_q[32*(MAX_NK-j)-1 -: 32];
        end
    end

    // win_q[0] holds w[i-1]; win_q[nk-1] holds w[i-Nk].
    assign prev_w = win_q[0];
    assign rot_w  = {prev_w[23:0], prev_w[31:24]};
    assign sub_in = (m_q == 3'd0) ? rot_w : prev_w;

    key_sched_subword u_subword (
        .src_word(sub_in),
        .sub_word(sub_out)
    );

    always_comb begin
        back_w = win_q[0];
        for (int j = 0; j < MAX_NK; j++) begin
            if (4'(j + 1) == nk_q) back_w = win_q[j];
        end
        temp_w = prev_w;
        if (m_q == 3'd0) begin
            temp_w = sub_out ^ {rcon_q, 24'h0};
        end else if (nk_q == 4'd8 && m_q == 3'd4) begin
            temp_w = sub_out;
        end
        new_w = back_w ^ temp_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_en  = 1'b0;
        exp_en   = 1'b0;
        done_d   = 1'b0;
        valid_d  = valid_q;
        nr_out_d = nr_out_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    valid_d = 1'b0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                load_en = 1'b1;
                state_d = StExpand;
            end
            StExpand: begin
                exp_en = 1'b1;
                if (last_word) begin
                    done_d   = 1'b1;
                    valid_d  = 1'b1;
                    nr_out_d = nr_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            nr_out_q <= 4'd0;
            rcon_q   <= RCON_INIT;
            i_q      <= '0;
            m_q      <= 3'd0;
            nk_q     <= 4'd4;
            nr_q     <= 4'd10;
            key_q    <= '0;
        end else begin
            done_q   <= done_d;
            valid_q  <= valid_d;
            nr_out_q <= nr_out_d;
            if (accept) begin
                key_q <= key_in;
                nk_q  <= cfg.nk;
                nr_q  <= cfg.nr;
            end
            if (load_en) begin
                i_q    <= AW'(nk_q);
                m_q    <= 3'd0;
                rcon_q <= RCON_INIT;
            end else if (exp_en) begin
                i_q <= i_q + AW'(1);
                m_q <= m_next;
                if (m_q == 3'd0) rcon_q <= xtime(rcon_q);
            end
        end
    end

    // Schedule storage and window carry no reset; valid qualifies their contents.
    always_ff @(posedge clk) begin
        if (load_en) begin
            for (int j = 0; j < MAX_NK; j++) begin
                if (4'(j) < nk_q) mem[j] <= key_w[j];
                for (int s = 0; s < MAX_NK; s++) begin
                    if (4'(s + j + 1) == nk_q) win_q[j] <= key_w[s];
                end
            end
        end else if (exp_en) begin
            mem[i_q] <= new_w;
            win_q[0] <= new_w;
            for (int j = 1; j < MAX_NK; j++) begin
                win_q[j] <= win_q[j-1];
            end
        end
    end

    logic [3:0]   eff_idx;
    logic [127:0] rk_d;

    always_comb begin
`ifdef KEY_SCHED_DEC_EN
        eff_idx = rk_rev ? (nr_out_q - rk_idx) : rk_idx;
`else
        eff_idx = rk_idx;
`endif
        rk_d = '0;
        if (rk_idx <= nr_out_q) begin
            for (int k = 0; k < 4; k++) begin
                rk_d[127-32*k -: 32] = mem[AW'({eff_idx, 2'(k)})];
            end
        end
    end

    if (RD_REG != 0) begin : g_rd_reg
        logic [127:0] rk_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rk_q <= '0;
            end else begin
                rk_q <= rk_d;
            end
        end
        assign rk_out = rk_q;
    end else begin : g_rd_comb
        assign rk_out = rk_d;
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign valid  = valid_q;
    assign nr_out = nr_out_q;

endmodule

// File: tb/tb_key_sched_gen.sv
// Bench for key_sched_gen: FIPS-197 expansions, latency, boundary reads and reset abort.
// Builds with or without KEY_SCHED_DEC_EN.
module tb_key_sched_gen;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         valid;
    logic [3:0]   nr_out;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
`ifdef KEY_SCHED_DEC_EN
    logic         rk_rev;
`endif

    localparam logic [127:0] K128     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192     = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256     =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK128_9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] RK256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    key_sched_gen #(
        .MAX_NK(8),
        .RD_REG(1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .key_len(key_len),
        .key_in (key_in),
        .busy   (busy),
        .done   (done),
        .valid  (valid),
        .nr_out (nr_out),
        .rk_idx (rk_idx),
`ifdef KEY_SCHED_DEC_EN
        .rk_rev (rk_rev),
`endif
        .rk_out (rk_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] exp_q[$];
    string        tag_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Start one expansion and follow it to done; inject_at > 0 re-pulses start mid-run.
    task automatic expand(input logic [1:0] kl, input logic [255:0] key, input int exp_lat,
                          input int inject_at, input logic [3:0] exp_nr, input string tag);
        int cyc;
        @(negedge clk);
        key_len = kl;
        key_in  = key;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " busy_after_start"}, 128'(busy), 128'd1);
        check({tag, " valid_dropped"}, 128'(valid), 128'd0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == inject_at) begin
                start   = 1'b1;
                key_len = KL_128;
                key_in  = ~key;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, " latency"}, 128'(cyc), 128'(exp_lat));
        check({tag, " nr_out"}, 128'(nr_out), 128'(exp_nr));
        check({tag, " valid_set"}, 128'(valid), 128'd1);
        check({tag, " busy_clear"}, 128'(busy), 128'd0);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, 128'(done), 128'd0);
    endtask

    task automatic read_rk(input logic [3:0] idx, input logic [127:0] expv, input string tag);
        @(negedge clk);
        rk_idx = idx;
`ifdef KEY_SCHED_DEC_EN
        rk_rev = 1'b0;
`endif
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check(tag_q.pop_front(), rk_out, exp_q.pop_front());
    endtask

`ifdef KEY_SCHED_DEC_EN
    task automatic read_rev(input logic [3:0] idx, input logic [127:0] expv, input string tag);
        @(negedge clk);
        rk_idx = idx;
        rk_rev = 1'b1;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check(tag_q.pop_front(), rk_out, exp_q.pop_front());
        rk_rev = 1'b0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        key_len = KL_128;
        key_in  = '0;
        rk_idx  = 4'd0;
`ifdef KEY_SCHED_DEC_EN
        rk_rev  = 1'b0;
`endif
        #12;
        check("reset busy", 128'(busy), 128'd0);
        check("reset done", 128'(done), 128'd0);
        check("reset valid", 128'(valid), 128'd0);
        check("reset nr_out", 128'(nr_out), 128'd0);
        check("reset rk_out", rk_out, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        expand(KL_128, {K128, 128'h0}, 41, 0, 4'd10, "aes128");
        read_rk(4'd0, K128, "aes128 rk0");
        read_rk(4'd1, RK128_1, "aes128 rk1");
        read_rk(4'd10, RK128_10, "aes128 rk10");
        read_rk(4'd11, 128'h0, "aes128 rk11_zero");
        read_rk(4'd15, 128'h0, "aes128 rk15_zero");

        expand(KL_192, {K192, 64'h0}, 47, 0, 4'd12, "aes192");
        read_rk(4'd1, RK192_1, "aes192 rk1");
        read_rk(4'd12, RK192_12, "aes192 rk12");
        read_rk(4'd13, 128'h0, "aes192 rk13_zero");

        expand(KL_256, K256, 53, 0, 4'd14, "aes256");
        read_rk(4'd1, RK256_1, "aes256 rk1");
        read_rk(4'd2, RK256_2, "aes256 rk2");
        read_rk(4'd14, RK256_14, "aes256 rk14");

        expand(KL_128, {K128, 128'h0}, 41, 10, 4'd10, "restart_ignored");
        read_rk(4'd1, RK128_1, "restart_ignored rk1");
        read_rk(4'd10, RK128_10, "restart_ignored rk10");

        expand(2'b11, {K128, 128'hdeadbeef_cafef00d_01234567_89abcdef}, 41, 0, 4'd10, "reserved");
        read_rk(4'd10, RK128_10, "reserved rk10");

        // Abort an AES-256 run partway through with an asynchronous reset.
        @(negedge clk);
        key_len = KL_256;
        key_in  = K256;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        check("abort busy_before", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 128'(busy), 128'd0);
        check("abort valid", 128'(valid), 128'd0);
        check("abort done", 128'(done), 128'd0);
        check("abort rk_out", rk_out, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort valid_held", 128'(valid), 128'd0);

        expand(KL_128, {K128, 128'h0}, 41, 0, 4'd10, "after_abort");
        read_rk(4'd0, K128, "after_abort rk0");
        read_rk(4'd1, RK128_1, "after_abort rk1");
        read_rk(4'd10, RK128_10, "after_abort rk10");

`ifdef KEY_SCHED_DEC_EN
        read_rev(4'd0, RK128_10, "rev rk0");
        read_rev(4'd1, RK128_9, "rev rk1");
        read_rev(4'd10, K128, "rev rk10");
        read_rev(4'd11, 128'h0, "rev rk11_zero");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_sched_gen.md
Name: key_sched_gen

Overview:
- Sequential, parametrised AES key-schedule engine for AES-128, AES-192 and AES-256.
- Expands a cipher key into the full round-key set, producing one 32-bit schedule word per cycle, and stores it internally.
- Serves 128-bit round keys through an indexed read port to the round datapath.
- Replaces per-round combinational key_gen chains; Rcon is generated internally, not supplied per round.

Parameters:
- MAX_NK, 8, largest supported key length in 32-bit words (4, 6 or 8); sets key_in width and storage depth (4*(MAX_NK+7) words).
- RD_REG, 1, 1 = rk_out registered (1-cycle read latency); 0 = combinational read.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request expansion; sampled only in IDLE
- key_len  in  2  00=128, 01=192, 10=256, 11=reserved (treated as 128)
- key_in  in  32*MAX_NK  key, left-justified; w0 = key_in[MSB -: 32]
- busy  out  1  high from the accepted start until the last word is written
- done  out  1  one-cycle pulse when expansion completes
- valid  out  1  round-key set complete and readable
- nr_out  out  4  round count of the stored set: 10, 12 or 14
- rk_idx  in  4  round-key index 0..Nr
- rk_out  out  128  words 4*rk_idx..4*rk_idx+3; word 4*rk_idx in bits [127:96]

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, done, valid = 0; nr_out = 0; rk_out = 0; Rcon = 0x01; storage contents need not clear.
- FSM IDLE -> LOAD -> EXPAND -> IDLE.
  - IDLE: start=1 latches key_in and key_len, sets busy=1, clears valid, goes to LOAD.
  - LOAD (1 cycle): writes w[0..Nk-1] to storage, fills a sliding window of the last Nk words, sets i=Nk, goes to EXPAND.
  - EXPAND: one word per cycle, w[i] = w[i-Nk] ^ temp with temp = w[i-1], modified as follows:
    - if i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {Rcon,24'h0}, then Rcon = xtime(Rcon) (0x80 -> 0x1b).
    - else if Nk == 8 and i mod Nk == 4: temp = SubWord(temp).
  - Last write (i = 4*(Nr+1)-1): same edge sets done=1 (for 1 cycle), valid=1, busy=0, nr_out=Nr; returns to IDLE.
- Latency from the edge sampling start to done high: 41 cycles (128), 47 (192), 53 (256).
- Counters use i mod Nk, not division; RotWord is a left rotate by one byte; byte order big-endian within words.
- start while busy is ignored. A new start in IDLE with valid=1 drops valid on the next edge.
- key_len requesting more words than MAX_NK supports is treated as 128.
- rk_idx > Nr returns all zeros. Reads while valid=0 return stale data; no error flag.
- Reset mid-expansion aborts immediately; valid stays 0 until a new full expansion completes.

Optional Feature:
- Macro KEY_SCHED_DEC_EN.
- Defined: adds input rk_rev (1 bit). When rk_rev=1, rk_out returns round key Nr-rk_idx (decryption order, same latency).
- Undefined: no rk_rev port; forward order only.

Decomposition:
- Shared package aes_pkg:
  - key_len encoding constants (KL_128, KL_192, KL_256).
  - Nk/Nr lookup function.
  - xtime function.
  - RCON_INIT = 8'h01.
- Sub-module key_sched_subword: 32-bit SubWord built from four instances of the existing sbox (high/low nibble inputs, byte out). Instantiated once and shared by the RotWord and Nk==8 paths.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - done exactly 41 cycles later; nr_out=10.
  - rk_idx=1 -> a0fafe1788542cb123a339392a6c7605; rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done after 47 cycles; rk_idx=12 -> e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done after 53 cycles; rk_idx=14 -> fe4890d1e6188d0b046df344706c631e.
- Boundaries:
  - start re-asserted mid-expansion -> ignored, result unchanged.
  - rk_idx=11 in AES-128 -> rk_out=0.
  - key_len=11 -> behaves as AES-128.
- Reset asserted at cycle 20 of an AES-256 run:
  - busy, valid, done = 0 immediately.
  - Subsequent AES-128 run gives the correct keys.
- With KEY_SCHED_DEC_EN, AES-128: rk_rev=1, rk_idx=0 -> d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx=10 -> original key.
